// File: rtl/udma_filter_stream_framer.sv
// udma_filter_stream_framer: normalises raw samples, tags sof/eof per frame and buffers them for the uDMA filter stream input.
// Latency: a sample accepted at edge k is on filter_* in cycle k+1 when the FIFO was empty; one sample per cycle sustained.
// Backpressure: in_ready_o is low when the FIFO is full or outside RUN. UDMA_FILTER_FRAMER_SIGNEXT_EN enables sign extension.

module udma_filter_stream_framer_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q;
    logic [PW-1:0]    rd_q;
    logic [PW:0]      cnt_q;

    // Caller never pushes when full nor pops when empty.
    always_ff @(posedge clk_i) begin
        if (push_i && !clr_i) begin
            mem_q[wr_q] <= push_dat_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + PW'(1);
            if (pop_i)  rd_q <= rd_q + PW'(1);
            if (push_i && !pop_i) begin
                cnt_q <= cnt_q + (PW+1)'(1);
            end else if (!push_i && pop_i) begin
                cnt_q <= cnt_q - (PW+1)'(1);
            end
        end
    end

    assign head_dat_o = mem_q[rd_q];
    assign empty_o    = (cnt_q == '0);
    assign full_o     = (cnt_q == (PW+1)'(DEPTH));
endmodule

module udma_filter_stream_framer #(
    parameter int DATA_WIDTH   = 32,
    parameter int FILTID_WIDTH = 8,
    parameter int TRANS_SIZE   = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cfg_en_i,
    input  logic                    cfg_clr_i,
    input  logic [TRANS_SIZE-1:0]   cfg_frame_len_i,
    input  logic [FILTID_WIDTH-1:0] cfg_filter_id_i,
    input  logic [1:0]              cfg_datasize_i,
    input  logic                    cfg_signed_i,
    input  logic [DATA_WIDTH-1:0]   in_data_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    output logic [FILTID_WIDTH-1:0] filter_id_o,
    output logic [DATA_WIDTH-1:0]   filter_data_o,
    output logic [1:0]              filter_datasize_o,
    output logic                    filter_valid_o,
    output logic                    filter_sof_o,
    output logic                    filter_eof_o,
    input  logic                    filter_ready_i,
    output logic                    busy_o,
    output logic                    frame_done_o,
    output logic [TRANS_SIZE-1:0]   frame_cnt_o
);
    localparam int EW = FILTID_WIDTH + 4 + DATA_WIDTH;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [TRANS_SIZE-1:0]   len_q, len_d;
    logic [FILTID_WIDTH-1:0] id_q, id_d;
    logic [1:0]              ds_q, ds_d;
    logic [TRANS_SIZE-1:0]   idx_q, idx_d;
    logic [TRANS_SIZE-1:0]   cnt_q, cnt_d;
    logic                    done_q, done_d;
    logic                    sx;

`ifdef UDMA_FILTER_FRAMER_SIGNEXT_EN
    logic signed_q, signed_d;
    assign sx = signed_q;
`else
    logic unused_cfg_signed;
    assign unused_cfg_signed = cfg_signed_i;
    assign sx = 1'b0;
`endif

    logic                  fifo_empty, fifo_full, push, pop, sof, eof;
    logic [DATA_WIDTH-1:0] norm;
    logic [EW-1:0]         head_dat;

    assign in_ready_o = (state_q == ST_RUN) && !fifo_full && !cfg_clr_i;
    assign push       = in_valid_i && in_ready_o;
    assign pop        = !fifo_empty && filter_ready_i;
    assign sof        = (idx_q == '0);
    assign eof        = (idx_q == len_q);

    always_comb begin
        norm = in_data_i;
        case (ds_q)
            2'd0: begin
                norm      = {DATA_WIDTH{sx & in_data_i[7]}};
                norm[7:0] = in_data_i[7:0];
            end
            2'd1: begin
                norm       = {DATA_WIDTH{sx & in_data_i[15]}};
                norm[15:0] = in_data_i[15:0];
            end
            default: norm = in_data_i;
        endcase
    end

    udma_filter_stream_framer_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (cfg_clr_i),
        .push_i     (push),
        .push_dat_i ({id_q, ds_q, sof, eof, norm}),
        .pop_i      (pop),
        .head_dat_o (head_dat),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        id_d    = id_q;
        ds_d    = ds_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        done_d  = pop && head_dat[DATA_WIDTH];
`ifdef UDMA_FILTER_FRAMER_SIGNEXT_EN
        signed_d = signed_q;
`endif
        if (done_d) cnt_d = cnt_q + TRANS_SIZE'(1);
        if (push)   idx_d = eof ? '0 : idx_q + TRANS_SIZE'(1);
        case (state_q)
            ST_IDLE: begin
                if (cfg_en_i) begin
                    state_d = ST_RUN;
                    len_d   = cfg_frame_len_i;
                    id_d    = cfg_filter_id_i;
                    ds_d    = cfg_datasize_i;
                    idx_d   = '0;
                    cnt_d   = '0;
`ifdef UDMA_FILTER_FRAMER_SIGNEXT_EN
                    signed_d = cfg_signed_i;
`endif
                end
            end
            // Stop only on a frame boundary so no partial frame leaves the block.
            ST_RUN:   if (!cfg_en_i && idx_d == '0) state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_empty) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (cfg_clr_i) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            id_q    <= '0;
            ds_q    <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
`ifdef UDMA_FILTER_FRAMER_SIGNEXT_EN
            signed_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            id_q    <= id_d;
            ds_q    <= ds_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
`ifdef UDMA_FILTER_FRAMER_SIGNEXT_EN
            signed_q <= signed_d;
`endif
        end
    end

    assign filter_valid_o    = !fifo_empty;
    assign filter_data_o     = filter_valid_o ? head_dat[DATA_WIDTH-1:0] : '0;
    assign filter_eof_o      = filter_valid_o && head_dat[DATA_WIDTH];
    assign filter_sof_o      = filter_valid_o && head_dat[DATA_WIDTH+1];
    assign filter_datasize_o = filter_valid_o ? head_dat[DATA_WIDTH+3:DATA_WIDTH+2] : 2'b00;
    assign filter_id_o       = filter_valid_o ? head_dat[EW-1:DATA_WIDTH+4] : '0;
    assign busy_o            = (state_q != ST_IDLE);
    assign frame_done_o      = done_q;
    assign frame_cnt_o       = cnt_q;
endmodule

// File: tb/tb_udma_filter_stream_framer.sv
// Randomised and directed bench for udma_filter_stream_framer against a queue-based frame model.
module tb_udma_filter_stream_framer;
    localparam int FD = 4;
`ifdef UDMA_FILTER_FRAMER_SIGNEXT_EN
    localparam bit SEXT = 1'b1;
`else
    localparam bit SEXT = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cfg_en_i, cfg_clr_i, cfg_signed_i;
    logic [15:0] cfg_frame_len_i;
    logic [7:0]  cfg_filter_id_i;
    logic [1:0]  cfg_datasize_i;
    logic [31:0] in_data_i;
    logic        in_valid_i, in_ready_o;
    logic [7:0]  filter_id_o;
    logic [31:0] filter_data_o;
    logic [1:0]  filter_datasize_o;
    logic        filter_valid_o, filter_sof_o, filter_eof_o, filter_ready_i;
    logic        busy_o, frame_done_o;
    logic [15:0] frame_cnt_o;

    always #5 clk_i = ~clk_i;

    udma_filter_stream_framer dut (
        .clk_i(clk_i), .rst_i(rst_i), .cfg_en_i(cfg_en_i), .cfg_clr_i(cfg_clr_i),
        .cfg_frame_len_i(cfg_frame_len_i), .cfg_filter_id_i(cfg_filter_id_i),
        .cfg_datasize_i(cfg_datasize_i), .cfg_signed_i(cfg_signed_i),
        .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .filter_id_o(filter_id_o), .filter_data_o(filter_data_o),
        .filter_datasize_o(filter_datasize_o), .filter_valid_o(filter_valid_o),
        .filter_sof_o(filter_sof_o), .filter_eof_o(filter_eof_o),
        .filter_ready_i(filter_ready_i), .busy_o(busy_o),
        .frame_done_o(frame_done_o), .frame_cnt_o(frame_cnt_o)
    );

    typedef struct packed {
        logic [7:0]  id;
        logic [1:0]  ds;
        logic        sof;
        logic        eof;
        logic [31:0] d;
    } ent_t;

    int vectors = 0;
    int miscompares = 0;

    ent_t        mq[$];
    ent_t        obs[$];
    logic [31:0] src[$];
    int          m_st;      // 0 idle, 1 running, 2 draining
    int          m_idx, m_len;
    logic [7:0]  m_id;
    logic [1:0]  m_ds;
    logic        m_sg;
    logic [15:0] m_cnt;
    logic        m_done;
    int          done_seen = 0;
    int          vld_pct = 100;
    int          rdy_pct = 100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name, input int bound);
        vectors++;
        miscompares++;
        $display("FAIL %s: not reached within %0d cycles, required completion", name, bound);
    endtask

    function automatic logic [31:0] norm(input logic [31:0] x, input logic [1:0] ds, input logic sg);
        logic s;
        s = sg & SEXT;
        if (ds == 2'd0) return (s && x[7])  ? (x | 32'hFFFF_FF00) : (x & 32'h0000_00FF);
        if (ds == 2'd1) return (s && x[15]) ? (x | 32'hFFFF_0000) : (x & 32'h0000_FFFF);
        return x;
    endfunction

    // Per-cycle compare against the model, then advance the model across the coming edge.
    always @(negedge clk_i) begin
        ent_t h, e;
        bit   hv, rdy_exp, pop, push, was_empty;
        if (rst_i) begin
            check("rst_ready", in_ready_o, 0);
            check("rst_valid", filter_valid_o, 0);
            check("rst_data", filter_data_o, 0);
            check("rst_busy", busy_o, 0);
            check("rst_cnt", frame_cnt_o, 0);
            mq.delete();
            m_st = 0; m_idx = 0; m_cnt = '0; m_done = 1'b0;
        end else begin
            hv      = (mq.size() > 0);
            rdy_exp = (m_st == 1) && (mq.size() < FD) && !cfg_clr_i;
            h       = hv ? mq[0] : '0;
            check("in_ready", in_ready_o, rdy_exp);
            check("valid", filter_valid_o, hv);
            check("data", filter_data_o, h.d);
            check("id", filter_id_o, h.id);
            check("datasize", filter_datasize_o, h.ds);
            check("sof", filter_sof_o, h.sof);
            check("eof", filter_eof_o, h.eof);
            check("busy", busy_o, m_st != 0);
            check("frame_done", frame_done_o, m_done);
            check("frame_cnt", frame_cnt_o, m_cnt);
            if (filter_valid_o && filter_ready_i)
                obs.push_back({filter_id_o, filter_datasize_o, filter_sof_o, filter_eof_o, filter_data_o});
            if (frame_done_o) done_seen++;
            if (cfg_clr_i) begin
                mq.delete();
                m_st = 0; m_idx = 0; m_cnt = '0; m_done = 1'b0;
            end else begin
                pop       = hv && filter_ready_i;
                push      = rdy_exp && in_valid_i;
                was_empty = (mq.size() == 0);
                m_done    = pop && mq[0].eof;
                if (m_done) m_cnt++;
                if (pop) void'(mq.pop_front());
                if (push) begin
                    e.d   = norm(in_data_i, m_ds, m_sg);
                    e.id  = m_id;
                    e.ds  = m_ds;
                    e.sof = (m_idx == 0);
                    e.eof = (m_idx == m_len);
                    mq.push_back(e);
                    m_idx = e.eof ? 0 : m_idx + 1;
                    if (src.size() > 0) void'(src.pop_front());
                end
                if (m_st == 0 && cfg_en_i) begin
                    m_st = 1; m_len = int'(cfg_frame_len_i); m_id = cfg_filter_id_i;
                    m_ds = (cfg_datasize_i == 2'd3) ? 2'd3 : cfg_datasize_i;
                    m_sg = cfg_signed_i; m_idx = 0; m_cnt = '0;
                end else if (m_st == 1 && !cfg_en_i && m_idx == 0) begin
                    m_st = 2;
                end else if (m_st == 2 && was_empty) begin
                    m_st = 0;
                end
            end
        end
    end

    // Source/sink: offers src[0] and randomises consumer readiness after the driver has settled.
    initial begin
        in_valid_i = 1'b0; in_data_i = '0; filter_ready_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #2;
            in_valid_i     = (src.size() > 0) && ($urandom_range(99) < vld_pct);
            in_data_i      = (src.size() > 0) ? src[0] : $urandom;
            filter_ready_i = ($urandom_range(99) < rdy_pct);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic wait_src_le(input int n, input int bound, input string nm);
        int k = 0;
        while (src.size() > n && k < bound) begin cyc(); k++; end
        if (src.size() > n) timeout(nm, bound);
    endtask

    task automatic wait_obs(input int n, input int bound, input string nm);
        int k = 0;
        while (obs.size() < n && k < bound) begin cyc(); k++; end
        if (obs.size() < n) timeout(nm, bound);
    endtask

    task automatic wait_done(input int n, input int bound, input string nm);
        int k = 0;
        while (done_seen < n && k < bound) begin cyc(); k++; end
        if (done_seen < n) timeout(nm, bound);
    endtask

    task automatic start(input int len, input logic [7:0] id, input logic [1:0] ds, input logic sg);
        cfg_frame_len_i = 16'(len); cfg_filter_id_i = id; cfg_datasize_i = ds; cfg_signed_i = sg;
        cfg_en_i = 1'b1;
        cyc();
        // Later config changes must be ignored by the running block.
        cfg_frame_len_i = 16'($urandom); cfg_filter_id_i = 8'($urandom);
        cfg_datasize_i = 2'($urandom); cfg_signed_i = 1'($urandom);
    endtask

    task automatic stop();
        int k = 0;
        cfg_en_i = 1'b0;
        while ((busy_o || mq.size() > 0) && k < 3000) begin cyc(); k++; end
        if (busy_o) timeout("stop_idle", 3000);
        cyc(2);
    endtask

    initial begin
        int n, nfr, len;
        rst_i = 1'b0; cfg_en_i = 1'b0; cfg_clr_i = 1'b0; cfg_signed_i = 1'b0;
        cfg_frame_len_i = '0; cfg_filter_id_i = '0; cfg_datasize_i = '0;
        #1 rst_i = 1'b1;
        #11;
        check("reset_ready", in_ready_o, 0);
        check("reset_valid", filter_valid_o, 0);
        check("reset_cnt", frame_cnt_o, 0);
        @(posedge clk_i); #1 rst_i = 1'b0;
        cyc(2);

        // Two 4-sample word frames at full throughput.
        obs.delete(); done_seen = 0;
        start(3, 8'h5A, 2'd2, 1'b0);
        for (int i = 1; i <= 8; i++) src.push_back(i);
        wait_obs(8, 200, "t1_obs");
        cyc(3);
        check("t1_frame_cnt", frame_cnt_o, 2);
        check("t1_done_pulses", done_seen, 2);
        if (obs.size() >= 8)
            for (int i = 0; i < 8; i++) begin
                check("t1_data", obs[i].d, i + 1);
                check("t1_sof", obs[i].sof, (i % 4) == 0);
                check("t1_eof", obs[i].eof, (i % 4) == 3);
                check("t1_id", obs[i].id, 8'h5A);
            end
        stop();
        check("t1_cnt_held", frame_cnt_o, 2);

        // Narrow sample normalisation.
        obs.delete();
        start(0, 8'h11, 2'd0, 1'b1);
        src.push_back(32'hFFFF_FF80);
        wait_obs(1, 100, "t2_byte");
        if (obs.size() >= 1) check("t2_byte_signed", obs[0].d, SEXT ? 32'hFFFF_FF80 : 32'h0000_0080);
        stop();
        obs.delete();
        start(0, 8'h22, 2'd1, 1'b0);
        src.push_back(32'h1234_8001);
        wait_obs(1, 100, "t2_half");
        if (obs.size() >= 1) check("t2_half_unsigned", obs[0].d, 32'h0000_8001);
        stop();

        // Fill the FIFO with the consumer stalled.
        obs.delete(); rdy_pct = 0;
        start(5, 8'h33, 2'd2, 1'b0);
        for (int i = 0; i < 6; i++) src.push_back(32'h100 + i);
        cyc(12);
        check("t3_accepted_left", src.size(), 2);
        check("t3_ready_full", in_ready_o, 0);
        check("t3_valid_full", filter_valid_o, 1);
        rdy_pct = 100;
        wait_obs(6, 100, "t3_obs");
        if (obs.size() >= 6)
            for (int i = 0; i < 6; i++) check("t3_order", obs[i].d, 32'h100 + i);
        stop();

        // Enable dropped mid-frame: the frame completes, nothing further is taken.
        obs.delete();
        start(3, 8'h44, 2'd2, 1'b0);
        for (int i = 1; i <= 5; i++) src.push_back(i);
        wait_src_le(3, 100, "t4_two");
        cfg_en_i = 1'b0;
        stop();
        cyc(4);
        check("t4_left", src.size(), 1);
        check("t4_obs", obs.size(), 4);
        if (obs.size() >= 4) check("t4_last_eof", obs[3].eof, 1);
        src.delete();

        // Randomised frames, widths, handshakes and stop points.
        for (int r = 0; r < 16; r++) begin
            len = $urandom_range(4);
            nfr = $urandom_range(1, 4);
            n   = nfr * (len + 1);
            vld_pct = $urandom_range(30, 100);
            rdy_pct = $urandom_range(20, 100);
            start(len, 8'($urandom), 2'($urandom), 1'($urandom));
            for (int i = 0; i < n; i++) src.push_back($urandom);
            if ($urandom_range(1) == 1) wait_src_le($urandom_range(n - 1), 2000, "t5_mid");
            else wait_src_le(0, 2000, "t5_all");
            stop();
            src.delete();
        end
        vld_pct = 100; rdy_pct = 100;

        // Flush with three entries buffered.
        rdy_pct = 0;
        start(7, 8'h55, 2'd2, 1'b0);
        for (int i = 0; i < 5; i++) src.push_back(i + 10);
        wait_src_le(2, 100, "t7_fill");
        cfg_clr_i = 1'b1; cfg_en_i = 1'b0;
        cyc();
        cfg_clr_i = 1'b0;
        check("t7_valid", filter_valid_o, 0);
        check("t7_cnt", frame_cnt_o, 0);
        check("t7_busy", busy_o, 0);
        src.delete(); rdy_pct = 100;
        cyc(3);

        // Asynchronous reset mid-run.
        rdy_pct = 0;
        start(3, 8'h66, 2'd2, 1'b0);
        for (int i = 0; i < 10; i++) src.push_back(i);
        wait_src_le(8, 100, "t8_fill");
        check("t8_busy_before", busy_o, 1);
        @(posedge clk_i); #3 rst_i = 1'b1;
        #1;
        check("t8_ready", in_ready_o, 0);
        check("t8_valid", filter_valid_o, 0);
        check("t8_data", filter_data_o, 0);
        check("t8_sof", filter_sof_o, 0);
        check("t8_busy", busy_o, 0);
        check("t8_cnt", frame_cnt_o, 0);
        src.delete(); cfg_en_i = 1'b0; rdy_pct = 100;
        cyc(2);
        rst_i = 1'b0;
        cyc(2);

        // Single-sample frames and frame counter wrap.
        done_seen = 0;
        start(0, 8'h77, 2'd2, 1'b0);
        for (int i = 0; i < 65535; i++) src.push_back(i);
        wait_done(65535, 70000, "t6_wrap");
        obs.delete();
        cyc(3);
        check("t6_cnt_max", frame_cnt_o, 16'hFFFF);
        src.push_back(32'hABCD);
        wait_done(65536, 50, "t6_last");
        cyc(3);
        check("t6_cnt_wrap", frame_cnt_o, 16'h0000);
        if (obs.size() >= 1) check("t6_sof_eof", {obs[0].sof, obs[0].eof}, 2'b11);
        stop();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/udma_filter_stream_framer.md
# udma_filter_stream_framer

Upstream feeder for the uDMA filter's direct stream input. It takes raw peripheral samples, normalises each one to the configured sample width, and tags frame boundaries (sof/eof) over a programmable frame length. It buffers the tagged samples in a small FIFO and presents them on the filter_id/data/datasize/valid/sof/eof/ready interface that the filter consumes in its stream-input modes.

## Interface
- DATA_WIDTH, 32, sample/data width
- FILTID_WIDTH, 8, filter id width
- TRANS_SIZE, 16, width of frame-length and frame-counter fields
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥2)

Ports. Clock and reset are fixed: one clock; reset is asynchronous and active-high.
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- cfg_en_i  in  1  level; framing enable
- cfg_clr_i  in  1  synchronous flush pulse
- cfg_frame_len_i  in  TRANS_SIZE  samples per frame minus 1
- cfg_filter_id_i  in  FILTID_WIDTH  id stamped on every sample
- cfg_datasize_i  in  2  0=byte, 1=half, 2=word (3 treated as word)
- cfg_signed_i  in  1  sign-extend narrow samples (macro-dependent)
- in_data_i  in  DATA_WIDTH  raw sample
- in_valid_i  in  1  sample valid
- in_ready_o  out  1  sample accepted when valid&ready
- filter_id_o  out  FILTID_WIDTH  id of head entry
- filter_data_o  out  DATA_WIDTH  normalised sample
- filter_datasize_o  out  2  datasize of head entry
- filter_valid_o  out  1  head entry valid
- filter_sof_o  out  1  head entry is the first sample of its frame
- filter_eof_o  out  1  head entry is the last sample of its frame
- filter_ready_i  in  1  consumer ready
- busy_o  out  1  state != IDLE
- frame_done_o  out  1  one-cycle pulse when the eof entry is consumed
- frame_cnt_o  out  TRANS_SIZE  completed frames since start

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE→RUN on cfg_en_i=1. On that edge, cfg_frame_len_i, cfg_filter_id_i, cfg_datasize_i and cfg_signed_i are captured into shadow registers; the sample index and frame_cnt_o are cleared. Later config changes are ignored until the next start.
- RUN: in_ready_o = !full. Each accepted sample is normalised and pushed together with the shadow id, the shadow datasize, sof=(idx==0) and eof=(idx==len).
  - idx increments per accepted sample and wraps to 0 after idx==len.
  - len=0 gives 1-sample frames with sof=eof=1.
- Normalisation: byte keeps bits [7:0], half keeps bits [15:0], and the upper bits are zero-filled (or sign-filled, see Configuration). Word passes through unchanged.
- cfg_en_i=0 while in RUN:
  - If idx==0, go to DRAIN immediately.
  - Otherwise keep accepting samples until the eof sample is pushed, then go to DRAIN. No partial frame is ever emitted.
- DRAIN: in_ready_o=0. Go to IDLE when the FIFO is empty and no pop is pending. If cfg_en_i=1 in DRAIN, stay in DRAIN until the FIFO is empty, then go to IDLE; the next start is taken from IDLE.
- cfg_clr_i (any state) takes priority over everything: the FIFO is emptied, idx=0, frame_cnt_o=0, state=IDLE. A push in the same cycle is discarded; in_ready_o is forced to 0 that cycle.
- Pop occurs when filter_valid_o & filter_ready_i.
  - frame_done_o pulses in the cycle after a pop of an eof entry.
  - frame_cnt_o increments in that same cycle and wraps modulo 2^TRANS_SIZE.

## Timing
- Reset values: in_ready_o=0, filter_valid_o=0, all filter_* outputs 0, busy_o=0, frame_done_o=0, frame_cnt_o=0; state=IDLE; FIFO empty.
- All filter_* outputs are forced to 0 while filter_valid_o=0.
- Latency: a sample accepted at edge k appears on filter_* in cycle k+1 if the FIFO was empty.
- in_ready_o is driven combinationally from registered state and the FIFO level only; it does not depend on in_valid_i or filter_ready_i.
- FIFO behaviour:
  - When full, in_ready_o=0, even if a pop happens in the same cycle.
  - A simultaneous push and pop with the FIFO neither empty nor full leaves the level unchanged.
  - Ordering is strictly FIFO.
- filter_valid_o may not drop without a pop, except on cfg_clr_i or rst_i.
- Full throughput is one sample per cycle when filter_ready_i is held at 1.

## Configuration
- UDMA_FILTER_FRAMER_SIGNEXT_EN:
  - Defined: when cfg_signed_i=1, byte and half samples are sign-extended from bit 7 or bit 15.
  - Undefined: samples are always zero-extended; cfg_signed_i is ignored and its capture register is omitted.
- Word samples are unaffected in both cases.

## Test plan
- len=3, id=0x5A, word, 8 samples 1..8, ready=1 → outputs 1..8 in order; sof on 1 and 5, eof on 4 and 8; id=0x5A; frame_cnt_o=2; two frame_done_o pulses.
- byte size, sample 0xFFFF_FF80, signed=1 → 0xFFFF_FF80 with the macro defined; 0x0000_0080 without it. Half size, 0x1234_8001, signed=0 → 0x0000_8001.
- FIFO_DEPTH=4, ready=0, 6 samples offered → 4 accepted, then in_ready_o=0; raise ready → 4 pops with valid held, then in_ready_o=1 again.
- len=3, drop cfg_en_i after 2 samples → samples 3 and 4 are still accepted (4 carries eof), then DRAIN; busy_o falls after the last pop; sample 5 is never accepted.
- len=0 → every output has sof=eof=1; frame_cnt_o counts 0xFFFF→0x0000 after 65536 frames (wrap check with TRANS_SIZE=16).
- Mid-frame cfg_clr_i with 3 entries buffered → next cycle filter_valid_o=0, frame_cnt_o=0, busy_o=0. rst_i asserted mid-RUN → all outputs are at reset values immediately, with no clock edge.
